spike_readout: RTL and testbench
================================

# spike_readout

Windowed rate decoder on the output side of the recurrent neuron. It treats each bit of the neuron's 8-bit `out` word as one channel's spike. It counts spikes per channel over a fixed window of accepted samples, then scans the counts for the winning channel. The result is presented on a valid/ready interface to the downstream consumer.

## Interface
- `WINDOW`, default 16: accepted samples per window; legal range 1..255.
- `CW`, default 8: per-channel counter width; counters saturate at 2^CW−1.
- `clk`  input  1: single clock, rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `spikes`  input  8: spike word from the neuron; bit i is channel i.
- `in_valid`  input  1: `spikes` is valid this cycle.
- `in_ready`  output  1: block accepts samples. High only in ACCUM.
- `class_id`  output  3: winning channel index.
- `max_count`  output  CW: spike count of the winning channel.
- `out_valid`  output  1: result valid.
- `out_ready`  input  1: consumer accepts the result.

## Operation
- FSM states:
  - ACCUM (reset state).
  - SCAN.
  - HOLD.
- ACCUM:
  - A sample is accepted on a rising edge where `in_valid && in_ready`.
  - On acceptance, each channel counter cnt[i] increments by `spikes[i]`, saturating at 2^CW−1 (no wrap).
  - The sample counter (8 bit) increments only on accepted samples. Cycles with `in_valid`=0 do not advance the window.
  - On the edge that accepts sample number `WINDOW`: sample counter clears, scan index clears to 0, and the FSM goes to SCAN.
- SCAN:
  - One channel is compared per cycle, index 0 through 7.
  - Best value and best index are reset before index 0.
  - Channel i replaces the current best only if cnt[i] > best (strictly greater). Ties therefore resolve to the lowest index.
  - If all counts are zero, the result is class 0 with count 0.
  - After index 7 is evaluated, `class_id` and `max_count` are registered, `out_valid` is set, and the FSM goes to HOLD.
- HOLD:
  - `out_valid`=1. `class_id` and `max_count` stay stable until the handshake.
  - `in_ready`=0, so `in_valid` is ignored and no counter changes.
  - On the edge where `out_valid && out_ready`: `out_valid` clears, all channel counters clear, and the FSM returns to ACCUM.
  - `class_id` and `max_count` keep their last value after the handshake. They are only meaningful while `out_valid`=1.
- Windows never overlap. Samples offered during SCAN or HOLD are not accepted and are not counted in any window.
- Asynchronous reset, effective immediately in any state:
  - FSM goes to ACCUM.
  - All channel counters, the sample counter and the scan index clear to 0.
  - `out_valid`=0, `class_id`=0, `max_count`=0.
  - `in_ready`=1 (decoded from state).
  - A reset during SCAN or HOLD discards the pending result.

## Timing
- `in_ready` is a combinational decode of the state (ACCUM). There is no combinational path from `in_valid` or `out_ready` to any output.
- Let E be the edge that accepts the final sample of a window. SCAN evaluates on edges E+1 through E+8. `out_valid` is high from edge E+8.
- Result latency is 8 cycles after the last accepted sample.
- If `out_ready` is already high, the handshake completes on edge E+9. `in_ready` is high from E+9, and the first sample of the next window can be accepted on edge E+10.
- Minimum window period is WINDOW + 9 cycles.
- Arithmetic:
  - Counters are unsigned CW-bit values.
  - Comparisons are unsigned.
  - A counter already at 2^CW−1 holds its value on further spikes.

## Test plan
- Basic count: reset, then 16 back-to-back samples of `spikes`=8'h04 with `in_valid`=1 and `out_ready`=1 → `out_valid` rises 8 cycles after the 16th accept with `class_id`=2 and `max_count`=16. The handshake occurs on the next edge.
- Tie-break: 16 samples of 8'h22 (channels 1 and 5 equal) → `class_id`=1, `max_count`=16. Then 16 samples of 8'h00 → `class_id`=0, `max_count`=0.
- Saturation: with CW=4 and WINDOW=20, 20 samples of 8'h80 → `class_id`=7, `max_count`=15.
- Gapped input: 16 samples of 8'h08 interleaved with `in_valid`=0 cycles and with `in_valid`=1, `spikes`=8'hFF cycles issued while in SCAN/HOLD → `class_id`=3, `max_count`=16. Non-accepted cycles are not counted.
- Backpressure: hold `out_ready`=0 for 10 cycles in HOLD while driving `in_valid`=1, `spikes`=8'hFF → `out_valid`, `class_id` and `max_count` stay stable and `in_ready`=0. After `out_ready` rises, the next window starts from all-zero counts.
- Reset mid-operation: assert `rst_n`=0 asynchronously during SCAN, and again during HOLD → `out_valid`=0, `class_id`=0, `max_count`=0 and `in_ready`=1 immediately. The next full window decodes correctly.

Source files
------------

// File: rtl/spike_readout.sv
`default_nettype none
// ============================================================================
// Module   : spike_readout
// Brief    : Windowed per-channel spike-rate decoder with argmax result output.
// Revision : 1.0 - initial release
// ============================================================================

module spike_readout #(
   parameter int WINDOW = 16,
   parameter int CW     = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    spikes,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [2:0]    class_id,
   output logic [CW-1:0] max_count,
   output logic          out_valid,
   input  logic          out_ready
);

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_SCAN  = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [7:0]    c_last_sample = 8'(WINDOW - 1);
   localparam logic [CW-1:0] c_cnt_max     = {CW{1'b1}};
   localparam logic [CW-1:0] c_cnt_one     = CW'(1);

   state_t        r_state;
   state_t        w_state_next;
   logic [7:0]    r_sample_cnt;
   logic [2:0]    r_scan_idx;
   logic [CW-1:0] r_best_val;
   logic [2:0]    r_best_idx;
   logic [2:0]    r_class_id;
   logic [CW-1:0] r_max_count;
   logic          r_out_valid;

   logic [CW-1:0] w_cnt [8];
   logic          w_accept;
   logic          w_window_done;
   logic          w_release;
   logic [CW-1:0] w_sel_val;
   logic [CW-1:0] w_base_val;
   logic [2:0]    w_base_idx;
   logic [CW-1:0] w_new_val;
   logic [2:0]    w_new_idx;

   assign in_ready      = (r_state == ST_ACCUM);
   assign class_id      = r_class_id;
   assign max_count     = r_max_count;
   assign out_valid     = r_out_valid;

   assign w_accept      = in_valid && in_ready;
   assign w_window_done = w_accept && (r_sample_cnt == c_last_sample);
   assign w_release     = (r_state == ST_HOLD) && r_out_valid && out_ready;

   // Per-channel saturating spike counters, cleared when the result is taken
   generate
      for (genvar g = 0; g < 8; g++) begin : g_chan
         logic [CW-1:0] r_cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= '0;
            end else if (w_release) begin
               r_cnt <= '0;
            end else if (w_accept && spikes[g] && (r_cnt != c_cnt_max)) begin
               r_cnt <= r_cnt + c_cnt_one;
            end
         end

         assign w_cnt[g] = r_cnt;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_ACCUM: if (w_window_done)       w_state_next = ST_SCAN;
         ST_SCAN:  if (r_scan_idx == 3'd7)  w_state_next = ST_HOLD;
         ST_HOLD:  if (w_release)           w_state_next = ST_ACCUM;
         default:                           w_state_next = ST_ACCUM;
      endcase
   end

   // Index 0 compares against a zero best, so an all-zero window yields class 0
   always_comb begin
      w_sel_val  = w_cnt[r_scan_idx];
      w_base_val = r_best_val;
      w_base_idx = r_best_idx;
      if (r_scan_idx == 3'd0) begin
         w_base_val = '0;
         w_base_idx = 3'd0;
      end
      w_new_val = w_base_val;
      w_new_idx = w_base_idx;
      if (w_sel_val > w_base_val) begin
         w_new_val = w_sel_val;
         w_new_idx = r_scan_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample_cnt <= '0;
         r_scan_idx   <= '0;
         r_best_val   <= '0;
         r_best_idx   <= '0;
         r_class_id   <= '0;
         r_max_count  <= '0;
         r_out_valid  <= 1'b0;
      end else begin
         if (w_accept) begin
            if (w_window_done) begin
               r_sample_cnt <= '0;
               r_scan_idx   <= '0;
            end else begin
               r_sample_cnt <= r_sample_cnt + 8'd1;
            end
         end
         if (r_state == ST_SCAN) begin
            r_best_val <= w_new_val;
            r_best_idx <= w_new_idx;
            r_scan_idx <= r_scan_idx + 3'd1;
            if (r_scan_idx == 3'd7) begin
               r_class_id  <= w_new_idx;
               r_max_count <= w_new_val;
               r_out_valid <= 1'b1;
            end
         end
         if (w_release) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spike_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_readout
// Brief    : Self-checking bench for spike_readout against a count/argmax model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_spike_readout;

   localparam int WIN   = 16;
   localparam int CWD   = 8;
   localparam int S_WIN = 20;
   localparam int S_CW  = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [7:0]     spikes;
   logic           in_valid;
   logic           in_ready;
   logic [2:0]     class_id;
   logic [CWD-1:0] max_count;
   logic           out_valid;
   logic           out_ready;

   logic [7:0]      s_spikes;
   logic            s_in_valid;
   logic            s_in_ready;
   logic [2:0]      s_class_id;
   logic [S_CW-1:0] s_max_count;
   logic            s_out_valid;
   logic            s_out_ready;

   int checks = 0;
   int errors = 0;
   int model_cnt [8];

   always #5 clk = ~clk;

   spike_readout #(.WINDOW(WIN), .CW(CWD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spikes    (spikes),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .class_id  (class_id),
      .max_count (max_count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   spike_readout #(.WINDOW(S_WIN), .CW(S_CW)) dut_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .spikes    (s_spikes),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .class_id  (s_class_id),
      .max_count (s_max_count),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready)
   );

   function automatic int sat_add(input int v, input int lim);
      return (v < lim) ? v + 1 : lim;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Winner = largest count, earliest channel on ties, class 0 when all zero
   task automatic model_winner(output int cls, output int mx);
      cls = 0;
      mx  = 0;
      for (int ch = 0; ch < 8; ch++) begin
         if (model_cnt[ch] > mx) begin
            mx  = model_cnt[ch];
            cls = ch;
         end
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_class_id", class_id, 0);
      check("rst_max_count", max_count, 0);
      check("rst_in_ready", in_ready, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // mode 0: fixed pattern, mode 1: random spikes; abort 1 = reset in SCAN, 2 = reset in HOLD
   task automatic do_window(input int mode, input logic [7:0] pat, input int gap,
                            input int hold, input int abort, input int exp_cls, input int exp_max);
      int acc;
      int cyc;
      int cls;
      int mx;
      int lim;
      lim = (1 << CWD) - 1;
      for (int ch = 0; ch < 8; ch++) model_cnt[ch] = 0;
      acc = 0;
      cyc = 0;
      out_ready = (hold == 0);
      while (acc < WIN && cyc < 2000) begin
         @(negedge clk);
         check("accum_in_ready", in_ready, 1);
         check("accum_out_valid", out_valid, 0);
         in_valid = ($urandom_range(0, 99) >= gap);
         spikes   = (mode == 0) ? pat : 8'($urandom);
         @(posedge clk);
         if (in_valid) begin
            acc++;
            for (int ch = 0; ch < 8; ch++)
               if (spikes[ch]) model_cnt[ch] = sat_add(model_cnt[ch], lim);
         end
         cyc++;
      end
      check("window_filled", acc, WIN);
      model_winner(cls, mx);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         spikes   = 8'hFF;
         check("scan_in_ready", in_ready, 0);
         check("scan_out_valid", out_valid, 0);
         if (abort == 1 && k == 4) begin
            do_reset();
            return;
         end
         @(posedge clk);
      end
      @(negedge clk);
      check("result_valid", out_valid, 1);
      check("result_class", class_id, cls);
      check("result_max", max_count, mx);
      check("result_in_ready", in_ready, 0);
      if (exp_cls >= 0) begin
         check("directed_class", class_id, exp_cls);
         check("directed_max", max_count, exp_max);
      end
      if (abort == 2) begin
         do_reset();
         return;
      end
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_class", class_id, cls);
         check("hold_max", max_count, mx);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_valid", out_valid, 0);
      check("release_in_ready", in_ready, 1);
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int scnt;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      spikes      = 8'h00;
      out_ready   = 1'b1;
      s_in_valid  = 1'b0;
      s_spikes    = 8'h00;
      s_out_ready = 1'b1;
      #1;
      check("init_in_ready", in_ready, 1);
      check("init_out_valid", out_valid, 0);
      check("init_class_id", class_id, 0);
      check("init_max_count", max_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_window(0, 8'h04, 0, 0, 0, 2, 16);
      do_window(0, 8'h22, 0, 0, 0, 1, 16);
      do_window(0, 8'h00, 0, 0, 0, 0, 0);
      do_window(0, 8'h08, 50, 0, 0, 3, 16);
      do_window(0, 8'h01, 0, 10, 0, 0, 16);
      do_window(0, 8'h01, 0, 0, 0, 0, 16);
      for (int r = 0; r < 4; r++)
         do_window(1, 8'h00, 30, int'($urandom_range(0, 3)), 0, -1, -1);

      do_window(0, 8'h40, 0, 0, 1, -1, -1);
      do_window(0, 8'h40, 0, 5, 2, 6, 16);
      do_window(0, 8'h10, 0, 0, 0, 4, 16);

      scnt = 0;
      for (int n = 0; n < S_WIN; n++) begin
         @(negedge clk);
         check("sat_in_ready", s_in_ready, 1);
         s_in_valid = 1'b1;
         s_spikes   = 8'h80;
         scnt = sat_add(scnt, (1 << S_CW) - 1);
      end
      @(negedge clk);
      s_in_valid = 1'b0;
      lat = 1;
      while (!s_out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("sat_latency", lat, 9);
      check("sat_class", s_class_id, 7);
      check("sat_max_model", s_max_count, scnt);
      check("sat_max_directed", s_max_count, 15);
      @(negedge clk);
      check("sat_release", s_out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
